// File: rtl/multicycle_ctrl.sv
// Main control FSM for a multicycle RV32I core: sequences ALU, memory port, IR, PC and
// register file per instruction, stalling on the memory ready handshake.
module multicycle_ctrl #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic [1:0] o_immsrc,
  output logic [1:0] o_alusrca,
  output logic [1:0] o_alusrcb,
  output logic [1:0] o_resultsrc,
  output logic [2:0] o_alucontrol,
  output logic       o_adrsrc,
  output logic       o_irwrite,
  output logic       o_pcwrite,
  output logic       o_regwrite,
  output logic       o_memwrite,
  output logic       o_illegal,
  output logic       o_instret
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     state_q, state_d;
  logic       ready;
  logic       op_valid;
  logic [1:0] aluop;
  logic       irwrite, pcupdate, branch, regwrite, memwrite, illegal, instret;

  assign ready    = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
  assign op_valid = i_op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = ready ? DECODE : FETCH;
      DECODE: begin
        case (i_op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_JAL:       state_d = JAL;
          OP_BEQ:       state_d = BEQ;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = i_op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = ready ? MEMWB : MEMREAD;
      MEMWB:    state_d = FETCH;
      MEMWRITE: state_d = ready ? FETCH : MEMWRITE;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      ALUWB:    state_d = FETCH;
      JAL:      state_d = ALUWB;
      BEQ:      state_d = FETCH;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    o_alusrca   = 2'b00;
    o_alusrcb   = 2'b00;
    o_resultsrc = 2'b00;
    o_adrsrc    = 1'b0;
    aluop       = 2'b00;
    irwrite     = 1'b0;
    pcupdate    = 1'b0;
    branch      = 1'b0;
    regwrite    = 1'b0;
    memwrite    = 1'b0;
    illegal     = 1'b0;
    instret     = 1'b0;
    case (state_q)
      FETCH: begin
        o_alusrcb   = 2'b10;
        o_resultsrc = 2'b10;
        irwrite     = ready;
        pcupdate    = ready;
      end
      DECODE: begin
        o_alusrca = 2'b01;
        o_alusrcb = 2'b01;
        illegal   = ~op_valid;
      end
      MEMADR: begin
        o_alusrca = 2'b10;
        o_alusrcb = 2'b01;
      end
      MEMREAD:  o_adrsrc = 1'b1;
      MEMWB: begin
        o_resultsrc = 2'b01;
        regwrite    = 1'b1;
        instret     = 1'b1;
      end
      // memwrite stays asserted across every stall cycle
      MEMWRITE: begin
        o_adrsrc = 1'b1;
        memwrite = 1'b1;
        instret  = ready;
      end
      EXECUTER: begin
        o_alusrca = 2'b10;
        aluop     = 2'b10;
      end
      EXECUTEI: begin
        o_alusrca = 2'b10;
        o_alusrcb = 2'b01;
        aluop     = 2'b10;
      end
      ALUWB: begin
        regwrite = 1'b1;
        instret  = 1'b1;
      end
      JAL: begin
        o_alusrca = 2'b01;
        o_alusrcb = 2'b10;
        pcupdate  = 1'b1;
      end
      BEQ: begin
        o_alusrca = 2'b10;
        aluop     = 2'b01;
        branch    = 1'b1;
        instret   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_alucontrol = 3'b000;
    case (aluop)
      2'b01: o_alucontrol = 3'b001;
      2'b10: begin
        case (i_funct3)
          3'b000:  o_alucontrol = (i_op[5] & i_funct7b5) ? 3'b001 : 3'b000;
          3'b010:  o_alucontrol = 3'b101;
          3'b110:  o_alucontrol = 3'b011;
          3'b111:  o_alucontrol = 3'b010;
          default: o_alucontrol = 3'b000;
        endcase
      end
      default: o_alucontrol = 3'b000;
    endcase
  end

  always_comb begin
    case (i_op)
      OP_SW:   o_immsrc = 2'b01;
      OP_BEQ:  o_immsrc = 2'b10;
      OP_JAL:  o_immsrc = 2'b11;
      default: o_immsrc = 2'b00;
    endcase
  end

  // Reset suppresses every write enable and pulse, even combinationally.
  assign o_irwrite  = irwrite & ~i_rst;
  assign o_pcwrite  = (pcupdate | (branch & i_zero)) & ~i_rst;
  assign o_regwrite = regwrite & ~i_rst;
  assign o_memwrite = memwrite & ~i_rst;
  assign o_illegal  = illegal & ~i_rst;
  assign o_instret  = instret & ~i_rst;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction step sequences with random memory stalls,
// compared every cycle against a control-table model, plus literal cycle/pulse counts.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic       zero;
  logic       mem_ready;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic [2:0] alucontrol;
  logic       adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal, instret;

  multicycle_ctrl #(.MEM_HANDSHAKE(1'b1)) dut (
    .i_clk(clk), .i_rst(rst), .i_op(op), .i_funct3(f3), .i_funct7b5(f7b5),
    .i_zero(zero), .i_mem_ready(mem_ready),
    .o_immsrc(immsrc), .o_alusrca(alusrca), .o_alusrcb(alusrcb),
    .o_resultsrc(resultsrc), .o_alucontrol(alucontrol), .o_adrsrc(adrsrc),
    .o_irwrite(irwrite), .o_pcwrite(pcwrite), .o_regwrite(regwrite),
    .o_memwrite(memwrite), .o_illegal(illegal), .o_instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic [2:0] alucontrol;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;
    logic       instret;
  } ctrl_t;

  typedef enum int {
    ST_FETCH, ST_DECODE, ST_ADDR, ST_LOAD, ST_LOADWB, ST_STORE,
    ST_EXE_R, ST_EXE_I, ST_WB, ST_JUMP, ST_BRANCH
  } step_t;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_JAL = 4, C_BEQ = 5, C_ILL = 6;

  ctrl_t act, exp_c;
  logic  exp_valid = 1'b0;
  int    checks = 0;
  int    errors = 0;
  step_t cur_step;

  assign act = {immsrc, alusrca, alusrcb, resultsrc, alucontrol, adrsrc,
                irwrite, pcwrite, regwrite, memwrite, illegal, instret};

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f, input logic b);
    case (f)
      3'b000:  return (o == 7'b0110011 && b) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic supported(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
           o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
  endfunction

  // Expected control word for one step of an instruction.
  function automatic ctrl_t model(input step_t s, input logic rdy, input logic z,
                                  input logic in_rst, input logic [6:0] o,
                                  input logic [2:0] f, input logic b);
    ctrl_t c;
    c = '0;
    c.immsrc = imm_of(o);
    case (s)
      ST_FETCH:  begin c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.irwrite = rdy; c.pcwrite = rdy; end
      ST_DECODE: begin c.alusrca = 2'b01; c.alusrcb = 2'b01; c.illegal = !supported(o); end
      ST_ADDR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      ST_LOAD:   c.adrsrc = 1'b1;
      ST_LOADWB: begin c.resultsrc = 2'b01; c.regwrite = 1'b1; c.instret = 1'b1; end
      ST_STORE:  begin c.adrsrc = 1'b1; c.memwrite = 1'b1; c.instret = rdy; end
      ST_EXE_R:  begin c.alusrca = 2'b10; c.alucontrol = alu_of(o, f, b); end
      ST_EXE_I:  begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.alucontrol = alu_of(o, f, b); end
      ST_WB:     begin c.regwrite = 1'b1; c.instret = 1'b1; end
      ST_JUMP:   begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcwrite = 1'b1; end
      ST_BRANCH: begin c.alusrca = 2'b10; c.alucontrol = 3'b001; c.pcwrite = z; c.instret = 1'b1; end
      default: ;
    endcase
    if (in_rst) begin
      c.irwrite = 0; c.pcwrite = 0; c.regwrite = 0; c.memwrite = 0; c.illegal = 0; c.instret = 0;
    end
    return c;
  endfunction

  function automatic logic [6:0] op_of(input int cls);
    logic [6:0] bad [5];
    bad = '{7'b1110011, 7'b0110111, 7'b0010111, 7'b1100111, 7'b0000000};
    case (cls)
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_JAL:   return 7'b1101111;
      C_BEQ:   return 7'b1100011;
      default: return bad[$urandom_range(0, 4)];
    endcase
  endfunction

  always @(negedge clk) begin
    if (exp_valid) begin
      checks++;
      if (act !== exp_c)
        $display("FAIL ctrl t=%0t step=%s got=%05h exp=%05h", $time, cur_step.name(), act, exp_c);
      if (act !== exp_c) errors++;
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, want);
    end
  endtask

  // waits>=0: fetch ready at once, memory step ready after 'waits' stall cycles; -1 random.
  // zmode 0/1 fixed zero flag, 2 random. abort_at: step index where reset is pulsed.
  task automatic run_instr(input int cls, input logic [6:0] o, input logic [2:0] f,
                           input logic b, input int waits, input int zmode, input int abort_at,
                           output int n_instret, output int n_regwrite, output int n_memwrite,
                           output int n_pcwrite, output int n_illegal, output int instret_cyc,
                           output int regwrite_cyc, output logic [2:0] alu_seen);
    step_t seq[$];
    int    cyc, w;
    logic  rdy, z, is_wait;
    seq.delete();
    seq.push_back(ST_FETCH);
    seq.push_back(ST_DECODE);
    case (cls)
      C_LW:  begin seq.push_back(ST_ADDR); seq.push_back(ST_LOAD); seq.push_back(ST_LOADWB); end
      C_SW:  begin seq.push_back(ST_ADDR); seq.push_back(ST_STORE); end
      C_R:   begin seq.push_back(ST_EXE_R); seq.push_back(ST_WB); end
      C_I:   begin seq.push_back(ST_EXE_I); seq.push_back(ST_WB); end
      C_JAL: begin seq.push_back(ST_JUMP); seq.push_back(ST_WB); end
      C_BEQ: seq.push_back(ST_BRANCH);
      default: ;
    endcase
    cyc = 0; n_instret = 0; n_regwrite = 0; n_memwrite = 0; n_pcwrite = 0; n_illegal = 0;
    instret_cyc = -1; regwrite_cyc = -1; alu_seen = 3'b000;
    op = o; f3 = f; f7b5 = b;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        cur_step = ST_FETCH;
        exp_c = model(ST_FETCH, mem_ready, zero, 1'b1, o, f, b);
        @(negedge clk);
        n_regwrite += int'(regwrite);
        n_instret  += int'(instret);
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      w = 0;
      is_wait = seq[i] inside {ST_FETCH, ST_LOAD, ST_STORE};
      forever begin
        if (!is_wait)                rdy = 1'($urandom_range(0, 1));
        else if (waits < 0)          rdy = (w >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
        else if (seq[i] == ST_FETCH) rdy = 1'b1;
        else                         rdy = (w >= waits);
        z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
        mem_ready = rdy;
        zero      = z;
        cur_step  = seq[i];
        exp_c     = model(seq[i], rdy, z, 1'b0, o, f, b);
        exp_valid = 1'b1;
        @(negedge clk);
        cyc++;
        if (instret)  begin n_instret++; instret_cyc = cyc; end
        if (regwrite) begin n_regwrite++; regwrite_cyc = cyc; end
        n_memwrite += int'(memwrite);
        n_pcwrite  += int'(pcwrite);
        n_illegal  += int'(illegal);
        if (seq[i] inside {ST_EXE_R, ST_EXE_I}) alu_seen = alucontrol;
        @(posedge clk); #1;
        if (!is_wait || rdy) break;
        w++;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ni, nr, nm, np, nl, ic, rc, cls, ab;
    logic [2:0] al;
    rst = 1'b1; op = 7'b0000011; f3 = 3'b000; f7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    cur_step = ST_FETCH;
    exp_c = model(ST_FETCH, 1'b1, 1'b0, 1'b1, op, f3, f7b5);
    exp_valid = 1'b1;
    @(negedge clk);
    chk("reset_alusrcb", int'(alusrcb), 2);
    chk("reset_irwrite", int'(irwrite), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_instr(C_LW, 7'b0000011, 3'b010, 1'b0, 0, 0, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("lw_instret_cycle", ic, 5);
    chk("lw_regwrite_cycle", rc, 5);
    chk("lw_regwrite_count", nr, 1);

    run_instr(C_SW, 7'b0100011, 3'b010, 1'b0, 3, 0, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("sw_memwrite_count", nm, 4);
    chk("sw_instret_count", ni, 1);
    chk("sw_instret_cycle", ic, 7);

    run_instr(C_R, 7'b0110011, 3'b000, 1'b1, 0, 0, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("r_sub_alucontrol", int'(al), 1);
    chk("r_instret_cycle", ic, 4);

    run_instr(C_I, 7'b0010011, 3'b000, 1'b1, 0, 0, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("addi_alucontrol", int'(al), 0);

    run_instr(C_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 1, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("beq_taken_pcwrite", np, 2);
    chk("beq_instret_cycle", ic, 3);
    run_instr(C_BEQ, 7'b1100011, 3'b000, 1'b0, 0, 0, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("beq_nottaken_pcwrite", np, 1);

    run_instr(C_ILL, 7'b1110011, 3'b000, 1'b0, 0, 0, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("illegal_count", nl, 1);
    chk("illegal_instret", ni, 0);

    run_instr(C_JAL, 7'b1101111, 3'b000, 1'b0, 0, 0, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("jal_instret_cycle", ic, 4);
    chk("jal_pcwrite_count", np, 2);

    run_instr(C_R, 7'b0110011, 3'b110, 1'b0, 0, 0, 2, ni, nr, nm, np, nl, ic, rc, al);
    chk("abort_regwrite", nr, 0);
    chk("abort_instret", ni, 0);
    run_instr(C_LW, 7'b0000011, 3'b010, 1'b0, 0, 0, -1, ni, nr, nm, np, nl, ic, rc, al);
    chk("after_abort_lw_cycle", ic, 5);

    for (int k = 0; k < 250; k++) begin
      cls = $urandom_range(0, 6);
      ab  = ($urandom_range(0, 24) == 0) ? $urandom_range(0, 2) : -1;
      run_instr(cls, op_of(cls), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                -1, 2, ab, ni, nr, nm, np, nl, ic, rc, al);
    end

    exp_valid = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
